// File: rtl/bf_io_pkg.sv
// Shared definitions for the interpreter's I/O-side byte buffers.
//   eof_mode_t        : behaviour of an input buffer once EOF is latched and drained
//   EOF_VALUE_DEFAULT : byte presented in EOF_CONST mode unless overridden
package bf_io_pkg;

    typedef enum logic {
        EOF_STALL = 1'b0,  // never valid after drain; the core stalls on ','
        EOF_CONST = 1'b1   // present a fixed EOF byte forever after drain
    } eof_mode_t;

    localparam logic [7:0] EOF_VALUE_DEFAULT = 8'h00;

endpackage

// File: rtl/bf_byte_fifo.sv
// Show-ahead byte FIFO: storage, pointers, full/empty flags and occupancy.
//   clock, reset : single clock, synchronous active-high reset (pointers only)
//   push         : write push_data this cycle (caller guarantees !full)
//   pop          : retire the head byte this cycle (caller guarantees !empty)
//   head_data    : byte at the read pointer, valid whenever !empty
//   full, empty  : occupancy flags
//   count        : bytes currently stored
module bf_byte_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic [7:0]            push_data,
    input  logic                  pop,
    output logic [7:0]            head_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

    logic [7:0]          mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;

    // Pointers carry one extra bit so full and empty are distinguishable
    // without a separate occupancy register; they wrap naturally.
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: the storage array is deliberately not reset; only the pointers
    // define which entries are meaningful, and a reset on every entry would
    // prevent mapping onto RAM.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
    end

    assign head_data = mem[rd_ptr[DEPTH_LOG2-1:0]];
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                       (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign count     = wr_ptr - rd_ptr;

endmodule

// File: rtl/bf_input_buffer.sv
// Input-side byte buffer feeding the BF core's ',' port.
//   clock, reset          : single clock, synchronous active-high reset
//   host_data/valid/ready : host push handshake (ready independent of valid)
//   host_eof              : host declares end of input (level, may pulse)
//   in_val/in_valid       : byte presented to the core (show-ahead)
//   in_reading            : core is executing ',' and takes a byte if valid
//   count                 : bytes currently stored
//   eof_active            : EOF latched and FIFO drained
module bf_input_buffer
    import bf_io_pkg::*;
#(
    parameter int         DEPTH_LOG2 = 4,
    parameter eof_mode_t  EOF_MODE   = EOF_STALL,
    parameter logic [7:0] EOF_VALUE  = EOF_VALUE_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            host_data,
    input  logic                  host_valid,
    output logic                  host_ready,
    input  logic                  host_eof,
    output logic [7:0]            in_val,
    output logic                  in_valid,
    input  logic                  in_reading,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  eof_active
);

    localparam bit CONST_MODE = (EOF_MODE == EOF_CONST);

    logic                eof_latched;
    logic                full;
    logic                empty;
    logic                push;
    logic                pop;
    logic [7:0]          head_data;
    logic [DEPTH_LOG2:0] fifo_count;

    // Ready uses the pre-edge latch, so a push in the same cycle as host_eof
    // is still accepted. A pop never frees space for a same-cycle push.
    // Outputs are forced to their reset values while reset is held, and
    // nothing is pushed or popped during reset.
    assign host_ready = reset || (!full && !eof_latched);
    assign push       = !reset && host_valid && !full && !eof_latched;
    assign pop        = !reset && in_reading && !empty;

    always_ff @(posedge clock) begin
        if (reset)         eof_latched <= 1'b0;
        else if (host_eof) eof_latched <= 1'b1;
    end

    bf_byte_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (host_data),
        .pop       (pop),
        .head_data (head_data),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );

    // Drained reads in EOF_CONST mode return EOF_VALUE and consume nothing.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        in_valid = 1'b0;
        in_val   = 8'h00;
        if (!reset) begin
            if (!empty) begin
                in_valid = 1'b1;
                in_val   = head_data;
            end else if (CONST_MODE && eof_latched) begin
                in_valid = 1'b1;
                in_val   = EOF_VALUE;
            end
        end
    end

    assign count      = reset ? '0 : fifo_count;
    assign eof_active = !reset && eof_latched && empty;

endmodule

// File: tb/tb_bf_input_buffer.sv
// Self-checking bench for bf_input_buffer. Two instances share the clock and
// reset: unit 0 is EOF_STALL, unit 1 is EOF_CONST with EOF byte 8'hFF, both
// four bytes deep. A queue-based model predicts every output each cycle.
module tb_bf_input_buffer;
    import bf_io_pkg::*;

    localparam int DL2   = 2;
    localparam int DEPTH = 1 << DL2;

    logic           clock = 1'b0;
    logic           reset;
    logic [7:0]     host_data  [2];
    logic           host_valid [2];
    logic           host_eof   [2];
    logic           in_reading [2];
    logic           host_ready [2];
    logic [7:0]     in_val     [2];
    logic           in_valid   [2];
    logic [DL2:0]   count      [2];
    logic           eof_active [2];

    int checks = 0;
    int errors = 0;

    // Reference model: contents as a plain queue, plus the EOF flag.
    logic [7:0] mq [2][$];
    bit         meof [2];
    bit         accepted [2];

    always #5 clock = ~clock;

    bf_input_buffer #(.DEPTH_LOG2(DL2), .EOF_MODE(EOF_STALL), .EOF_VALUE(8'h00)) u_stall (
        .clock (clock), .reset (reset),
        .host_data (host_data[0]), .host_valid (host_valid[0]), .host_ready (host_ready[0]),
        .host_eof (host_eof[0]), .in_val (in_val[0]), .in_valid (in_valid[0]),
        .in_reading (in_reading[0]), .count (count[0]), .eof_active (eof_active[0])
    );

    bf_input_buffer #(.DEPTH_LOG2(DL2), .EOF_MODE(EOF_CONST), .EOF_VALUE(8'hFF)) u_const (
        .clock (clock), .reset (reset),
        .host_data (host_data[1]), .host_valid (host_valid[1]), .host_ready (host_ready[1]),
        .host_eof (host_eof[1]), .in_val (in_val[1]), .in_valid (in_valid[1]),
        .in_reading (in_reading[1]), .count (count[1]), .eof_active (eof_active[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        for (int i = 0; i < 2; i++) begin
            host_data[i]  = 8'h00;
            host_valid[i] = 1'b0;
            host_eof[i]   = 1'b0;
            in_reading[i] = 1'b0;
        end
    endtask

    task automatic drive(input int i, input bit v, input logic [7:0] d, input bit rd, input bit e);
        host_valid[i] = v;
        host_data[i]  = d;
        in_reading[i] = rd;
        host_eof[i]   = e;
    endtask

    // Inputs are already applied; check outputs, advance the model, then
    // move through one posedge to the following negedge.
    task automatic cycle();
        #1;
        for (int i = 0; i < 2; i++) begin
            int         sz = mq[i].size();
            bit         cm = (i == 1);
            bit         e_ready, e_valid, e_eofa;
            logic [7:0] e_val;
            int         e_cnt;
            if (reset) begin
                e_ready = 1'b1; e_valid = 1'b0; e_val = 8'h00; e_cnt = 0; e_eofa = 1'b0;
            end else begin
                e_ready = (sz < DEPTH) && !meof[i];
                e_valid = (sz > 0) || (meof[i] && cm);
                e_val   = (sz > 0) ? mq[i][0] : ((meof[i] && cm) ? 8'hFF : 8'h00);
                e_cnt   = sz;
                e_eofa  = meof[i] && (sz == 0);
            end
            check($sformatf("u%0d.host_ready", i), 32'(host_ready[i]), 32'(e_ready));
            check($sformatf("u%0d.in_valid", i),   32'(in_valid[i]),   32'(e_valid));
            check($sformatf("u%0d.in_val", i),     32'(in_val[i]),     32'(e_val));
            check($sformatf("u%0d.count", i),      32'(count[i]),      32'(e_cnt));
            check($sformatf("u%0d.eof_active", i), 32'(eof_active[i]), 32'(e_eofa));

            accepted[i] = 1'b0;
            if (reset) begin
                mq[i].delete();
                meof[i] = 1'b0;
            end else begin
                if (in_reading[i] && sz > 0) void'(mq[i].pop_front());
                if (host_valid[i] && e_ready) begin
                    mq[i].push_back(host_data[i]);
                    accepted[i] = 1'b1;
                end
                if (host_eof[i]) meof[i] = 1'b1;
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] seq [3];
        logic [7:0] nxt;
        int         rd_bias;

        seq[0] = 8'h41; seq[1] = 8'h42; seq[2] = 8'h43;
        idle();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;

        // Three back-to-back pushes, then three reads, then a stalled read.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 2; i++) drive(i, 1'b1, seq[k], 1'b0, 1'b0);
            cycle();
        end
        idle();
        cycle();
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 2; i++) drive(i, 1'b0, 8'h00, 1'b1, 1'b0);
            cycle();
        end

        // Fill to full with valid held, then 20+ push/pop pairs across wrap.
        do_reset();
        nxt = 8'h10;
        for (int k = 0; k < 30; k++) begin
            for (int i = 0; i < 2; i++) drive(i, 1'b1, nxt, (k >= 6), 1'b0);
            cycle();
            if (accepted[0]) nxt = nxt + 8'h01;
        end
        idle();
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 2; i++) drive(i, 1'b0, 8'h00, 1'b1, 1'b0);
            cycle();
        end

        // Simultaneous push and pop at count = 2.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 2; i++) drive(i, 1'b1, 8'h60 + 8'(k), 1'b0, 1'b0);
            cycle();
        end
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 2; i++) drive(i, 1'b1, 8'h70 + 8'(k), 1'b1, 1'b0);
            cycle();
        end

        // EOF on the stall unit: 30 accepted, 31 refused, then a drained stall.
        do_reset();
        drive(0, 1'b1, 8'h30, 1'b0, 1'b0);
        cycle();
        drive(0, 1'b0, 8'h00, 1'b0, 1'b1);
        cycle();
        for (int k = 0; k < 3; k++) begin
            drive(0, 1'b1, 8'h31, 1'b0, 1'b0);
            cycle();
        end
        for (int k = 0; k < 11; k++) begin
            drive(0, 1'b0, 8'h00, 1'b1, 1'b0);
            cycle();
        end
        idle();

        // EOF on the const unit with an empty FIFO, push in the same cycle as
        // host_eof on the stall unit, then reset mid-stream.
        do_reset();
        drive(1, 1'b0, 8'h00, 1'b0, 1'b1);
        drive(0, 1'b1, 8'h55, 1'b0, 1'b1);
        cycle();
        for (int k = 0; k < 5; k++) begin
            drive(1, 1'b0, 8'h00, 1'b1, 1'b0);
            drive(0, 1'b1, 8'h56, 1'b1, 1'b0);
            cycle();
        end
        drive(1, 1'b1, 8'h99, 1'b1, 1'b0);
        drive(0, 1'b1, 8'h99, 1'b1, 1'b0);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        idle();
        cycle();

        // Randomized traffic with varying read pressure, occasional EOF/reset.
        rd_bias = 1;
        for (int k = 0; k < 3000; k++) begin
            if (k % 150 == 0) rd_bias = int'($urandom_range(0, 4));
            for (int i = 0; i < 2; i++)
                drive(i, 1'($urandom_range(0, 1)), 8'($urandom),
                      ($urandom_range(0, 3) < rd_bias), ($urandom_range(0, 399) == 0));
            reset = ($urandom_range(0, 249) == 0);
            cycle();
        end
        reset = 1'b0;
        idle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
